// File: rtl/fifo_mem_ctrl_pkg.sv
// rtl/fifo_mem_ctrl_pkg.sv - shared defaults for the FIFO memory controller
//
// Default data/address widths of the memoria instance and the default
// almost-full / almost-empty thresholds that benches drive onto the
// threshold inputs.
package fifo_mem_ctrl_pkg;

  localparam int DATA_WIDTH_DEFAULT    = 10;
  localparam int ADDRESS_WIDTH_DEFAULT = 8;
  localparam int AEMPTY_THR_DEFAULT    = 2;

  // Default almost-full threshold: two entries below depth.
  function automatic int afull_thr_default(input int address_width);
    return (1 << address_width) - 2;
  endfunction

endpackage

// File: rtl/fifo_mem_ctrl.sv
// rtl/fifo_mem_ctrl.sv - pointer, occupancy and flag controller turning a memoria into a FIFO
//
// Ports:
//   clk, reset        : system clock, synchronous active-high reset
//   push, pop         : write / read requests (write data goes straight to memory)
//   afull_thr         : almost-full occupancy threshold (count >= thr)
//   aempty_thr        : almost-empty occupancy threshold (count <= thr)
//   wrmem_enable      : combinational write strobe, accepted push
//   rdmem_enable      : combinational read strobe, accepted pop
//   wr_addr, rd_addr  : registered memory pointers
//   count             : registered occupancy 0..depth
//   full, empty, almost_full, almost_empty : registered occupancy flags
//   data_valid        : memory read data valid, one cycle after rdmem_enable
//   overflow_err      : sticky, push seen while full
//   underflow_err     : sticky, pop seen while empty
module fifo_mem_ctrl
  import fifo_mem_ctrl_pkg::*;
#(
  parameter int data_width    = DATA_WIDTH_DEFAULT,
  parameter int address_width = ADDRESS_WIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [address_width:0]   afull_thr,
  input  logic [address_width:0]   aempty_thr,
  output logic                     wrmem_enable,
  output logic                     rdmem_enable,
  output logic [address_width-1:0] wr_addr,
  output logic [address_width-1:0] rd_addr,
  output logic [address_width:0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     data_valid,
  output logic                     overflow_err,
  output logic                     underflow_err
);

  // The data word only passes between requester and memory; it sizes nothing here.
  if (data_width < 1) begin : g_bad_data_width
    $error("fifo_mem_ctrl: data_width must be at least 1");
  end

  localparam logic [address_width:0] DEPTH_C = {1'b1, {address_width{1'b0}}};

  logic [address_width-1:0] wr_addr_q, wr_addr_d;
  logic [address_width-1:0] rd_addr_q, rd_addr_d;
  logic [address_width:0]   count_q, count_d;
  logic full_q, full_d;
  logic empty_q, empty_d;
  logic almost_full_q, almost_full_d;
  logic almost_empty_q, almost_empty_d;
  logic data_valid_q, data_valid_d;
  logic overflow_err_q, overflow_err_d;
  logic underflow_err_q, underflow_err_d;

  logic wr_acc;
  logic rd_acc;

  always_comb begin
    // Push is gated by full even when a pop is accepted in the same cycle,
    // so a write can never land on the slot being read.
    wr_acc = push & ~full_q & ~reset;
    rd_acc = pop & ~empty_q & ~reset;

    wr_addr_d = wr_addr_q + address_width'(wr_acc);
    rd_addr_d = rd_addr_q + address_width'(rd_acc);
    count_d   = count_q + (address_width + 1)'(wr_acc) - (address_width + 1)'(rd_acc);

    // Flags come from count_d so they line up with count after the edge.
    // thr = 0 makes almost_full true, thr >= depth makes almost_empty true.
    full_d         = (count_d == DEPTH_C);
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= afull_thr);
    almost_empty_d = (count_d <= aempty_thr);

    data_valid_d    = rd_acc;
    overflow_err_d  = overflow_err_q | (push & full_q);
    underflow_err_d = underflow_err_q | (pop & empty_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_addr_q       <= '0;
      rd_addr_q       <= '0;
      count_q         <= '0;
      full_q          <= 1'b0;
      empty_q         <= 1'b1;
      almost_full_q   <= 1'b0;
      almost_empty_q  <= 1'b1;
      data_valid_q    <= 1'b0;
      overflow_err_q  <= 1'b0;
      underflow_err_q <= 1'b0;
    end else begin
      wr_addr_q       <= wr_addr_d;
      rd_addr_q       <= rd_addr_d;
      count_q         <= count_d;
      full_q          <= full_d;
      empty_q         <= empty_d;
      almost_full_q   <= almost_full_d;
      almost_empty_q  <= almost_empty_d;
      data_valid_q    <= data_valid_d;
      overflow_err_q  <= overflow_err_d;
      underflow_err_q <= underflow_err_d;
    end
  end

  assign wrmem_enable  = wr_acc;
  assign rdmem_enable  = rd_acc;
  assign wr_addr       = wr_addr_q;
  assign rd_addr       = rd_addr_q;
  assign count         = count_q;
  assign full          = full_q;
  assign empty         = empty_q;
  assign almost_full   = almost_full_q;
  assign almost_empty  = almost_empty_q;
  assign data_valid    = data_valid_q;
  assign overflow_err  = overflow_err_q;
  assign underflow_err = underflow_err_q;

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// tb/tb_fifo_mem_ctrl.sv - self-checking bench for fifo_mem_ctrl with a small memory and a queue model
module tb_fifo_mem_ctrl;

  localparam int DW    = 10;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          push;
  logic          pop;
  logic [AW:0]   afull_thr;
  logic [AW:0]   aempty_thr;
  logic          wrmem_enable;
  logic          rdmem_enable;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          data_valid;
  logic          overflow_err;
  logic          underflow_err;

  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic [DW-1:0] mem [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the FIFO content as a queue plus accepted-op totals.
  logic [DW-1:0] model_q[$];
  int            n_pushed;
  int            n_popped;
  bit            m_ovf;
  bit            m_unf;
  bit            m_dv;
  logic [DW-1:0] m_rdata;

  always #5 clk = ~clk;

  fifo_mem_ctrl #(.data_width(DW), .address_width(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .afull_thr    (afull_thr),
    .aempty_thr   (aempty_thr),
    .wrmem_enable (wrmem_enable),
    .rdmem_enable (rdmem_enable),
    .wr_addr      (wr_addr),
    .rd_addr      (rd_addr),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .data_valid   (data_valid),
    .overflow_err (overflow_err),
    .underflow_err(underflow_err)
  );

  // Stand-in for memoria: registered read port.
  always @(posedge clk) begin
    if (wrmem_enable) mem[wr_addr] <= wdata;
    if (rdmem_enable) rdata <= mem[rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check strobes, advance model, check registers.
  task automatic step(input bit p, input bit q, input bit rst, input logic [DW-1:0] d);
    int  size;
    bit  e_w;
    bit  e_r;
    int  athr;
    int  ethr;
    push  = p;
    pop   = q;
    reset = rst;
    wdata = d;
    athr  = int'(afull_thr);
    ethr  = int'(aempty_thr);
    size  = model_q.size();
    e_w   = p && !rst && (size < DEPTH);
    e_r   = q && !rst && (size > 0);
    #1;
    check("wrmem_enable", 32'(wrmem_enable), 32'(e_w));
    check("rdmem_enable", 32'(rdmem_enable), 32'(e_r));
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      n_pushed = 0;
      n_popped = 0;
      m_ovf    = 0;
      m_unf    = 0;
      m_dv     = 0;
    end else begin
      if (p && size == DEPTH) m_ovf = 1;
      if (q && size == 0)     m_unf = 1;
      m_dv = e_r;
      if (e_r) begin
        m_rdata = model_q.pop_front();
        n_popped++;
      end
      if (e_w) begin
        model_q.push_back(d);
        n_pushed++;
      end
    end
    @(negedge clk);
    size = model_q.size();
    check("count",         32'(count),         32'(size));
    check("wr_addr",       32'(wr_addr),       32'(n_pushed % DEPTH));
    check("rd_addr",       32'(rd_addr),       32'(n_popped % DEPTH));
    check("full",          32'(full),          32'(size == DEPTH));
    check("empty",         32'(empty),         32'(size == 0));
    // Reset forces the almost flags to 0/1 regardless of threshold.
    check("almost_full",   32'(almost_full),   32'(rst ? 1'b0 : (size >= athr)));
    check("almost_empty",  32'(almost_empty),  32'(rst ? 1'b1 : (size <= ethr)));
    check("data_valid",    32'(data_valid),    32'(m_dv));
    check("overflow_err",  32'(overflow_err),  32'(m_ovf));
    check("underflow_err", 32'(underflow_err), 32'(m_unf));
    if (m_dv) check("read_data", 32'(rdata), 32'(m_rdata));
  endtask

  initial begin
    push       = 0;
    pop        = 0;
    reset      = 1;
    wdata      = '0;
    afull_thr  = 3'd3;
    aempty_thr = 3'd1;
    n_pushed   = 0;
    n_popped   = 0;
    m_ovf      = 0;
    m_unf      = 0;
    m_dv       = 0;
    m_rdata    = '0;
    @(negedge clk);
    step(0, 0, 1, '0);
    step(0, 0, 1, '0);

    // Fill with 0x001..0x004, then push into a full FIFO.
    for (int i = 1; i <= 4; i++) step(1, 0, 0, DW'(i));
    step(1, 0, 0, 10'h3ff);
    step(0, 0, 0, '0);
    // Drain in order, including the read-latency cycle of the last pop.
    for (int i = 0; i < 4; i++) step(0, 1, 0, '0);
    step(0, 0, 0, '0);
    // Empty: push+pop, only the push is taken.
    step(1, 1, 0, 10'h055);
    // Refill, then push+pop on full: only the pop is taken.
    for (int i = 0; i < 3; i++) step(1, 0, 0, DW'(10'h100 + i));
    step(1, 1, 0, 10'h2aa);
    step(0, 1, 0, '0);
    // Half full, simultaneous push+pop keeps count and wraps pointers.
    for (int i = 0; i < 10; i++) step(1, 1, 0, DW'(10'h200 + i));
    // Reset at count 3.
    step(1, 0, 0, 10'h077);
    check("count_before_reset", 32'(count), 32'd3);
    step(0, 0, 1, '0);

    // Threshold corners: afull_thr=0 and aempty_thr>=depth.
    afull_thr  = 3'd0;
    aempty_thr = 3'd4;
    step(0, 0, 0, '0);
    step(1, 0, 0, 10'h011);

    // Random traffic, thresholds and occasional reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        afull_thr  = 3'($urandom_range(0, 5));
        aempty_thr = 3'($urandom_range(0, 5));
      end
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 59) == 0), DW'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_mem_ctrl.md
Name: fifo_mem_ctrl

Overview:
Pointer and flag controller that turns a memoria instance (data_width 10, address_width 8) into a FIFO. It accepts push/pop requests, gates them against full/empty, and drives wrmem_enable/rdmem_enable plus write/read addresses to the memory. It also maintains occupancy, programmable almost-full/almost-empty flags and sticky error flags for the upstream flow-control logic.

Parameters:
data_width, 10, width of the data word in the memory (pass-through only; sizes no internal state)
address_width, 8, memory address width; depth = 2**address_width (default 256)

Ports:
clk  input  1  single system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
push  input  1  write request; data is presented to the memory by the requester in the same cycle
pop  input  1  read request
afull_thr  input  address_width+1  almost-full threshold (occupancy)
aempty_thr  input  address_width+1  almost-empty threshold (occupancy)
wrmem_enable  output  1  write strobe to memory (combinational)
rdmem_enable  output  1  read strobe to memory (combinational)
wr_addr  output  address_width  write pointer (registered)
rd_addr  output  address_width  read pointer (registered)
count  output  address_width+1  occupancy, 0..depth (registered)
full  output  1  count == depth
empty  output  1  count == 0
almost_full  output  1  count >= afull_thr
almost_empty  output  1  count <= aempty_thr
data_valid  output  1  memory read data valid, 1 cycle after rdmem_enable
overflow_err  output  1  sticky: push while full
underflow_err  output  1  sticky: pop while empty

Behaviour:
- Reset (sync, active-high): wr_addr=0, rd_addr=0, count=0, full=0, empty=1, almost_full=0, almost_empty=1, data_valid=0, overflow_err=0, underflow_err=0. wrmem_enable=rdmem_enable=0 while reset=1.
- Accept rules: wr_acc = push & ~full; rd_acc = pop & ~empty. wrmem_enable=wr_acc, rdmem_enable=rd_acc, both same cycle as the request.
- Push while full is rejected even if pop is also asserted; this avoids read/write collision on one slot. Pop is still accepted.
- Pop while empty is rejected; a simultaneous push is accepted.
- Pointers: wr_addr += 1 on wr_acc; rd_addr += 1 on rd_acc. Wrap modulo 2**address_width, with no special case at the top address.
- count_next = count + wr_acc - rd_acc. If both are accepted, count is unchanged.
- full, empty, almost_full and almost_empty are registered from count_next, so they are consistent with count in the same cycle.
- Thresholds are sampled every cycle. A threshold change takes effect on the flags at the next edge.
  - afull_thr = 0 forces almost_full = 1.
  - aempty_thr >= depth forces almost_empty = 1.
- data_valid <= rd_acc, giving 1-cycle read latency to match the memory registered output.
- overflow_err is set on push & full. underflow_err is set on pop & empty. Both clear only on reset.
- Reset mid-operation discards all contents. The flags return to reset values at the same edge, and data_valid drops on that edge.
- No FSM beyond pointer/count state. All outputs except the two enables are registered.

Decomposition:
- Shared include file fifo_defs.vh holds `define values for the default data/address widths and the default thresholds (afull = depth-2, aempty = 2) used by probadores.
- No sub-module needed.
- A bench-level wrapper instantiates fifo_mem_ctrl plus memoria; the wrapper is not part of this block.

Test Plan:
- Run with address_width=2 (depth 4). Reset, then push 4 words 0x001..0x004 -> wr_addr 0,1,2,3,0; count 1..4; full=1 after 4th; empty=0 after 1st.
- From full, push=1 -> wrmem_enable=0, overflow_err=1 next cycle and stays; count stays 4. Then pop 4 -> data_valid 1 cycle after each rdmem_enable, data out 0x001..0x004 in order, empty=1.
- Empty, push=pop=1 -> wrmem_enable=1, rdmem_enable=0, underflow_err=1, count=1.
- Full, push=pop=1 -> only rdmem_enable=1, count 4->3, overflow_err=1. Half-full, push=pop=1 for 10 cycles -> count constant at 2, pointers wrap past 3->0.
- With afull_thr=3 and aempty_thr=1: push to count 1 -> almost_empty=1; count 2 -> almost_empty=0; count 3 -> almost_full=1.
- At count=3, assert reset for 1 cycle -> next edge count=0, empty=1, pointers 0, errors 0, data_valid=0.
